// File: rtl/irq_ctrl_pkg.sv
// Shared types for the interrupt controller: FSM encoding and fixed-priority encoder.
// Priority is fixed: the lowest set bit wins.
package irq_ctrl_pkg;

  localparam int N_IRQ_DEFAULT = 8;
  localparam int PRIO_W        = 32;
  localparam int PRIO_IDX_W    = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } irq_state_e;

  typedef struct packed {
    logic                  vld;
    logic [PRIO_IDX_W-1:0] idx;
  } prio_t;

  // Scanning downwards means the last hit, the lowest index, is the one kept.
  function automatic prio_t prio_enc(input logic [PRIO_W-1:0] vec);
    prio_t r;
    r = '0;
    for (int i = PRIO_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.vld = 1'b1;
        r.idx = PRIO_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Interrupt line, mask and CPU request/ack/eoi bundle between sources, controller and CPU.
// slave = controller side, master = CPU/source side.
interface irq_ctrl_if import irq_ctrl_pkg::*; #(
  parameter int N_IRQ = N_IRQ_DEFAULT
) ();

  localparam int ID_W = $clog2(N_IRQ);

  logic [N_IRQ-1:0] irq_in;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_d;
  logic             int_ack;
  logic             int_eoi;
  logic [N_IRQ-1:0] int_e;
  logic [N_IRQ-1:0] pending;
  logic             in_service;
  logic [ID_W-1:0]  in_service_id;

  modport slave (
    input  irq_in, mask_we, mask_d, int_ack, int_eoi,
    output int_e, pending, in_service, in_service_id
  );

  modport master (
    output irq_in, mask_we, mask_d, int_ack, int_eoi,
    input  int_e, pending, in_service, in_service_id
  );

endinterface

// File: rtl/irq_sync_edge.sv
// Purpose: synchronise one async interrupt line and flag its rising edge.
// Latency: rise is valid SYNC_STAGES cycles after the line is sampled high.
// Backpressure: none; edges are single-cycle strobes the consumer must latch.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Purpose: latch interrupt edges, mask, prioritise and hand one one-hot request to the CPU.
// Latency: int_e rises one cycle after an unmasked event lands in pending.
// Backpressure: request held until int_ack or REQ_TIMEOUT; no new request until int_eoi.
module irq_ctrl import irq_ctrl_pkg::*; #(
  parameter int N_IRQ       = N_IRQ_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int REQ_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  irq_ctrl_if.slave   bus
);

  localparam int ID_W  = $clog2(N_IRQ);
  localparam int CNT_W = $clog2(REQ_TIMEOUT);

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] req_vec;
  logic [N_IRQ-1:0] int_e_q;
  logic             in_service_q;
  irq_state_e       state_q, state_n;
  logic [ID_W-1:0]  cur_q, cur_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  prio_t            win;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (bus.irq_in[i]),
      .rise  (rise[i])
    );
  end

  assign eligible = pending_q & mask_q;
  assign win      = prio_enc(PRIO_W'(eligible));

  always_comb begin
    state_n = state_q;
    cur_n   = cur_q;
    cnt_n   = cnt_q;
    ack_clr = '0;
    req_vec = '0;
    unique case (state_q)
      IDLE: begin
        if (win.vld) begin
          state_n = REQ;
          cur_n   = ID_W'(win.idx);
          cnt_n   = '0;
        end
      end
      REQ: begin
        // Ack beats a simultaneous EOI; no pre-emption by newer, higher-priority lines.
        if (bus.int_ack) begin
          state_n        = SERVICE;
          ack_clr[cur_q] = 1'b1;
        end else if (!mask_q[cur_q]) begin
          state_n = IDLE;
        end else if (cnt_q == CNT_W'(REQ_TIMEOUT - 1)) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      SERVICE: begin
        if (bus.int_eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    req_vec[cur_n] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      cnt_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      int_e_q      <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      cur_q        <= cur_n;
      cnt_q        <= cnt_n;
      // A fresh edge on the acked line survives the clear.
      pending_q    <= (pending_q & ~ack_clr) | rise;
      if (bus.mask_we) mask_q <= bus.mask_d;
      int_e_q      <= (state_n == REQ) ? req_vec : '0;
      in_service_q <= (state_n == SERVICE);
    end
  end

  assign bus.int_e         = int_e_q;
  assign bus.pending       = pending_q;
  assign bus.in_service    = in_service_q;
  assign bus.in_service_id = cur_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt request controller directly upstream of the CPU's 8-bit int_e input.
- Synchronises 8 asynchronous external interrupt lines and detects rising edges.
- Latches pending events, applies a software mask and fixed priority, and presents exactly one one-hot request to the CPU.
- Holds that request until the CPU acknowledges it, then tracks the in-service interrupt until end-of-interrupt (EOI).

Parameters:
- N_IRQ, 8, number of interrupt lines; equals the int_e width of the CPU.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser; minimum 2.
- REQ_TIMEOUT, 16, cycles a request waits unacknowledged before it is withdrawn and re-arbitrated; minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- irq_in  in  N_IRQ  asynchronous external interrupt lines, active-high.
- mask_we  in  1  write enable for the mask register.
- mask_d  in  N_IRQ  new mask value; bit=1 enables the line.
- int_ack  in  1  CPU accepted the current request; single-cycle pulse.
- int_eoi  in  1  CPU finished the service routine (reti); single-cycle pulse.
- int_e  out  N_IRQ  one-hot request to the CPU; all-zero when there is no request.
- pending  out  N_IRQ  latched pending events, including masked lines.
- in_service  out  1  high while an interrupt is being serviced.
- in_service_id  out  3  index of the request currently in REQ or SERVICE.

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchroniser chains, previous-value register, pending, mask, timeout counter and in_service_id all clear to 0.
  - FSM goes to IDLE; int_e=0 and in_service=0.
  - Any in-flight request or service is discarded; pending events are lost.
- Synchronisation and edge detection:
  - Each line passes through SYNC_STAGES flops.
  - rise[i] = sync[i] & ~prev[i].
  - A line already high when reset is released produces one edge SYNC_STAGES+1 cycles later.
- Pending:
  - pending[i] sets on rise[i].
  - pending[i] clears in the cycle int_ack is accepted for line i.
  - If rise[i] and that ack occur in the same cycle, pending[i] stays 1; the new event is not lost.
  - Multiple edges on one line before it is acked collapse into one event.
- Mask:
  - On mask_we, mask <= mask_d, effective the next cycle.
  - eligible = pending & mask.
- Priority: the lowest index wins (bit 0 highest).
- FSM, all outputs registered:
  - IDLE
    - eligible != 0 → REQ, latch cur = winning index, zero the timeout counter.
    - int_e goes one-hot the cycle after the edge is latched into pending (if the line is unmasked).
  - REQ
    - int_e = onehot(cur); in_service=0.
    - int_ack=1 → SERVICE, clear pending[cur], int_e=0 from the next cycle.
    - Else if mask[cur]=0 → IDLE; pending is kept.
    - Else if the counter equals REQ_TIMEOUT-1 → IDLE; pending is kept and re-arbitrated.
    - Else the counter increments.
    - A higher-priority line becoming eligible during REQ does not pre-empt; no nesting.
  - SERVICE
    - int_e=0; in_service=1; in_service_id=cur.
    - int_eoi=1 → IDLE.
    - New edges keep latching into pending.
- Spurious strobes: int_ack outside REQ and int_eoi outside SERVICE are ignored.
- If int_ack and int_eoi are both high in REQ, only the ack acts.
- Minimum spacing between back-to-back services: EOI → IDLE (1 cycle) → REQ.

Decomposition:
- Shared package holds:
  - N_IRQ_DEFAULT
  - FSM state encoding: IDLE=2'b00, REQ=2'b01, SERVICE=2'b10
  - priority-encoder function (lowest set bit → index, plus a valid flag)
- One natural sub-module: irq_sync_edge, a per-line synchroniser plus rising-edge detector, instantiated N_IRQ times via generate.

Test Plan:
1. Release reset; hold irq_in=0 with mask=8'hFF → int_e=0, pending=0 and in_service=0 for 20 cycles.
2. mask=8'hFF; pulse irq_in[3] for 1 cycle → pending=8'h08 and int_e=8'h08 SYNC_STAGES+2 cycles after the pulse. Then int_ack → pending=0, in_service=1, in_service_id=3. Then int_eoi → in_service=0.
3. Raise irq_in[5] and irq_in[2] simultaneously → int_e=8'h04 first. After ack and EOI → int_e=8'h20.
4. mask=8'h00; pulse irq_in[1] → pending=8'h02, int_e stays 0. Write mask=8'h02 → int_e=8'h02 two cycles later.
5. Request line 0 and never ack → int_e=8'h01 for exactly REQ_TIMEOUT cycles, 0 for one cycle, then 8'h01 again. Pull reset low while in REQ → int_e=0 asynchronously, and pending=0 after release.
6. In SERVICE for line 4, pulse irq_in[4] and assert int_ack → pending[4] sets and stays set. The ack is ignored: state stays SERVICE. After int_eoi → int_e=8'h10.
